// File: rtl/rf_wb_if.sv
// Writeback request bundle shared by NREQ requesters and the register-file write arbiter.
// Requester i uses bits [5i+4:5i] of req_addr and [32i+31:32i] of req_data.
interface rf_wb_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_addr;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin owner of the MIPS register-file write port. After reset it optionally
// clears registers 1..31 to CLR_VAL, then grants one writeback requester per cycle.
module rf_wb_arbiter #(
    parameter int          NREQ    = 3,
    parameter bit          INIT_EN = 1'b1,
    parameter logic [31:0] CLR_VAL = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    rf_wb_if.slave      bus,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic        rf_wr,
    output logic        init_done,
    output logic        zero_drop,
    output logic [15:0] wr_count
);
    localparam int             PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]    NREQ_W = (PW+1)'(NREQ);
    localparam logic [PW-1:0]  LAST   = PW'(NREQ - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [4:0]    clr_addr_q, clr_addr_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [4:0]    rf_a3_q, rf_a3_d;
    logic [31:0]   rf_wd_q, rf_wd_d;
    logic          rf_wr_q, rf_wr_d;
    logic          init_done_q, init_done_d;
    logic          zero_drop_q, zero_drop_d;
    logic [15:0]   wr_count_q, wr_count_d;

    logic [4:0]    addr_arr [NREQ];
    logic [31:0]   data_arr [NREQ];
    logic          gnt_any;
    logic [PW-1:0] gnt_idx;
    logic [PW:0]   sum;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = bus.req_addr[5*i +: 5];
        assign data_arr[i] = bus.req_data[32*i +: 32];
    end

    // First valid requester at or after rr_ptr, wrapping; ready is masked during reset and CLEAR.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        if (state_q == ST_RUN && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
                if (sum >= NREQ_W) sum = sum - NREQ_W;
                if (!gnt_any && bus.req_valid[sum[PW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = sum[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = gnt_any && (gnt_idx == PW'(i));
        end
    end

    assign sel_addr = addr_arr[gnt_idx];
    assign sel_data = data_arr[gnt_idx];

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rr_ptr_d    = rr_ptr_q;
        rf_a3_d     = rf_a3_q;
        rf_wd_d     = rf_wd_q;
        rf_wr_d     = 1'b0;
        init_done_d = init_done_q;
        zero_drop_d = 1'b0;
        wr_count_d  = wr_count_q;
        case (state_q)
            ST_CLEAR: begin
                // clr_addr wraps 31 -> 0, which marks the end of the sweep.
                if (clr_addr_q != 5'd0) begin
                    rf_wr_d    = 1'b1;
                    rf_a3_d    = clr_addr_q;
                    rf_wd_d    = CLR_VAL;
                    clr_addr_d = clr_addr_q + 5'd1;
                end else begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                init_done_d = 1'b1;
                if (gnt_any) begin
                    rr_ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
                    if (sel_addr == 5'd0) begin
                        zero_drop_d = 1'b1;
                    end else begin
                        rf_wr_d    = 1'b1;
                        rf_a3_d    = sel_addr;
                        rf_wd_d    = sel_data;
                        wr_count_d = sat_inc(wr_count_q);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_EN ? ST_CLEAR : ST_RUN;
            clr_addr_q  <= 5'd1;
            rr_ptr_q    <= '0;
            rf_a3_q     <= '0;
            rf_wd_q     <= '0;
            rf_wr_q     <= 1'b0;
            init_done_q <= 1'b0;
            zero_drop_q <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rr_ptr_q    <= rr_ptr_d;
            rf_a3_q     <= rf_a3_d;
            rf_wd_q     <= rf_wd_d;
            rf_wr_q     <= rf_wr_d;
            init_done_q <= init_done_d;
            zero_drop_q <= zero_drop_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign rf_a3     = rf_a3_q;
    assign rf_wd     = rf_wd_q;
    assign rf_wr     = rf_wr_q;
    assign init_done = init_done_q;
    assign zero_drop = zero_drop_q;
    assign wr_count  = wr_count_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: per-requester transaction queues drive the bus, a
// reference model predicts grants and register-file writes, a monitor compares outputs.
module tb_rf_wb_arbiter;
    localparam int          NREQ = 3;
    localparam logic [31:0] CLR  = 32'h0;
    localparam int          DEP  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wb_if #(.NREQ(NREQ)) bus ();
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        rf_wr, init_done, zero_drop;
    logic [15:0] wr_count;

    rf_wb_arbiter #(.NREQ(NREQ), .INIT_EN(1'b1), .CLR_VAL(CLR)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_wr(rf_wr),
        .init_done(init_done), .zero_drop(zero_drop), .wr_count(wr_count)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        zd;
        logic        id;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    int nchk = 0;
    int nfail = 0;

    // Pending transactions per requester (circular buffers).
    logic [4:0]  pa [NREQ][DEP];
    logic [31:0] pd [NREQ][DEP];
    int ph [NREQ];
    int pn [NREQ];

    // Reference model state.
    int          m_clr = 1;
    bit          m_run = 0;
    int          m_ptr = 0;
    int          m_cnt = 0;
    logic [4:0]  m_a3 = '0;
    logic [31:0] m_wd = '0;
    logic        nrst = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_req(input int r, input logic [4:0] a, input logic [31:0] d);
        if (pn[r] < DEP) begin
            pa[r][(ph[r] + pn[r]) % DEP] = a;
            pd[r][(ph[r] + pn[r]) % DEP] = d;
            pn[r]++;
        end
    endtask

    function automatic int pending_total();
        int s = 0;
        for (int r = 0; r < NREQ; r++) s += pn[r];
        return s;
    endfunction

    // One cycle: apply inputs at negedge, predict the next clock edge, check ready, queue expectation.
    task automatic step();
        logic [NREQ-1:0]   v;
        logic [5*NREQ-1:0] a;
        logic [32*NREQ-1:0] d;
        logic [NREQ-1:0]   exp_rdy;
        exp_t e;
        int g;
        @(negedge clk);
        rst = nrst;
        v = '0; a = '0; d = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (pn[r] > 0) begin
                v[r] = 1'b1;
                a[5*r +: 5]   = pa[r][ph[r]];
                d[32*r +: 32] = pd[r][ph[r]];
            end
        end
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        #1;
        exp_rdy = '0;
        e.wr = 1'b0; e.zd = 1'b0; e.id = 1'b0;
        if (rst) begin
            m_clr = 1; m_run = 0; m_ptr = 0; m_cnt = 0; m_a3 = '0; m_wd = '0;
        end else if (!m_run && m_clr <= 31) begin
            m_a3 = 5'(m_clr); m_wd = CLR; e.wr = 1'b1; m_clr++;
        end else if (!m_run) begin
            m_run = 1; e.id = 1'b1;
        end else begin
            e.id = 1'b1;
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && pn[(m_ptr + k) % NREQ] > 0) g = (m_ptr + k) % NREQ;
            end
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                if (pa[g][ph[g]] == 5'd0) begin
                    e.zd = 1'b1;
                end else begin
                    e.wr = 1'b1;
                    m_a3 = pa[g][ph[g]];
                    m_wd = pd[g][ph[g]];
                    if (m_cnt < 65535) m_cnt++;
                end
                ph[g] = (ph[g] + 1) % DEP;
                pn[g]--;
                m_ptr = (g + 1) % NREQ;
            end
        end
        e.a3 = m_a3; e.wd = m_wd; e.cnt = 16'(m_cnt);
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        sb.push_back(e);
    endtask

    // Monitor: compare registered outputs after every active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rf_wr",     64'(rf_wr),     64'(e.wr));
                chk("rf_a3",     64'(rf_a3),     64'(e.a3));
                chk("rf_wd",     64'(rf_wd),     64'(e.wd));
                chk("zero_drop", 64'(zero_drop), 64'(e.zd));
                chk("init_done", 64'(init_done), 64'(e.id));
                chk("wr_count",  64'(wr_count),  64'(e.cnt));
            end
        end
    end

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        for (int r = 0; r < NREQ; r++) begin ph[r] = 0; pn[r] = 0; end

        nrst = 1'b1;
        repeat (3) step();
        nrst = 1'b0;
        // Request raised during the clear sweep must be held until RUN.
        while (m_clr < 10) step();
        push_req(2, 5'd7, 32'hCAFE0002);
        repeat (26) step();

        push_req(1, 5'd5, 32'hDEADBEEF);
        repeat (3) step();

        for (int j = 0; j < 2; j++)
            for (int r = 0; r < NREQ; r++) push_req(r, 5'(8 + 3*j + r), 32'h100 * (j + 1) + r);
        repeat (8) step();

        push_req(0, 5'd0, 32'h1234);
        repeat (3) step();

        push_req(0, 5'd9, 32'hAAAA0000);
        push_req(1, 5'd9, 32'hBBBB1111);
        repeat (4) step();

        for (int c = 0; c < 300; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (pn[r] < 4 && $urandom_range(0, 2) == 0)
                    push_req(r, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
            end
            step();
        end

        // Reset while writes are pending; clear must restart from register 1.
        push_req(0, 5'd12, 32'h0BAD0C0D);
        nrst = 1'b1;
        step();
        nrst = 1'b0;
        repeat (40) step();

        for (int c = 0; c < 100; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if ($urandom_range(0, 1) == 0)
                    push_req(r, 5'($urandom), $urandom);
            end
            step();
        end

        n = 0;
        while (pending_total() > 0 && n < 500) begin
            step();
            n++;
        end
        chk("drain", 64'(pending_total()), 64'd0);
        repeat (3) step();
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
